// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register for an instruction pipeline.
//            Each entry carries a PC, a Tnew countdown and an opaque payload.
//            Tnew counts down by one per cycle while an entry is held
//            (saturating at 0), so hazard logic downstream always sees how
//            many cycles remain until the entry's result is available.
//            req (exception/interrupt) empties the stage and loads EXC_PC
//            into the output slot. flush empties the stage and zeroes the
//            output slot. req takes priority over flush, and flush takes
//            priority over the normal handshake.
// Config   : `define PIPE_STAGE_SKID_EN -> two entries (output slot + skid).
//            in_ready is then a pure register output, with no combinational
//            path from out_ready.
//            Undefined (default)     -> single output slot, and
//            in_ready = out_ready | ~out_valid.
// Ports    : clk                  rising-edge clock
//            reset                asynchronous, active-low reset
//            in_valid/in_ready    upstream handshake
//            in_pc/in_tnew/in_payload     upstream entry fields
//            out_valid/out_ready  downstream handshake
//            out_pc/out_tnew/out_payload  output slot fields (registered)
//            flush, req           bubble insertion / exception request
//            occupancy            number of valid entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          PAYLOAD_W = 32,
    parameter int          TNEW_W    = 4,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 flush,
    input  logic                 req,
    output logic [1:0]           occupancy
);

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? '0 : v - TNEW_W'(1);
    endfunction

    logic                 head_valid_q, head_valid_d;
    logic [31:0]          head_pc_q, head_pc_d;
    logic [TNEW_W-1:0]    head_tnew_q, head_tnew_d;
    logic [PAYLOAD_W-1:0] head_payload_q, head_payload_d;

    logic push;
    logic pop;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_valid_q, skid_valid_d;
    logic [31:0]          skid_pc_q, skid_pc_d;
    logic [TNEW_W-1:0]    skid_tnew_q, skid_tnew_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;

    // The skid slot is the only thing that can make the stage full, so
    // readiness comes straight off a flop.
    assign in_ready  = ~skid_valid_q;
    assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
`else
    assign in_ready  = out_ready | ~head_valid_q;
    assign occupancy = {1'b0, head_valid_q};
`endif

    assign push = in_valid & in_ready;
    assign pop  = head_valid_q & out_ready;

    always_comb begin
        head_valid_d   = head_valid_q;
        head_pc_d      = head_pc_q;
        head_tnew_d    = head_tnew_q;
        head_payload_d = head_payload_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d   = skid_valid_q;
        skid_pc_d      = skid_pc_q;
        skid_tnew_d    = skid_tnew_q;
        skid_payload_d = skid_payload_q;
`endif
        if (req) begin
            head_valid_d   = 1'b0;
            head_pc_d      = EXC_PC;
            head_tnew_d    = '0;
            head_payload_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_d   = 1'b0;
            skid_pc_d      = '0;
            skid_tnew_d    = '0;
            skid_payload_d = '0;
`endif
        end else if (flush) begin
            head_valid_d   = 1'b0;
            head_pc_d      = '0;
            head_tnew_d    = '0;
            head_payload_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_d   = 1'b0;
            skid_pc_d      = '0;
            skid_tnew_d    = '0;
            skid_payload_d = '0;
`endif
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            if (skid_valid_q) begin
                // Full: in_ready is low, so only a pop can change shape.
                if (pop) begin
                    head_valid_d   = 1'b1;
                    head_pc_d      = skid_pc_q;
                    head_tnew_d    = sat_dec(skid_tnew_q);
                    head_payload_d = skid_payload_q;
                    skid_valid_d   = 1'b0;
                end else begin
                    head_tnew_d = sat_dec(head_tnew_q);
                    skid_tnew_d = sat_dec(skid_tnew_q);
                end
            end else if (head_valid_q) begin
                if (push && pop) begin
                    head_pc_d      = in_pc;
                    head_tnew_d    = sat_dec(in_tnew);
                    head_payload_d = in_payload;
                end else if (push) begin
                    head_tnew_d    = sat_dec(head_tnew_q);
                    skid_valid_d   = 1'b1;
                    skid_pc_d      = in_pc;
                    skid_tnew_d    = sat_dec(in_tnew);
                    skid_payload_d = in_payload;
                end else if (pop) begin
                    // Fields are left as-is; only the valid bit drops.
                    head_valid_d = 1'b0;
                end else begin
                    head_tnew_d = sat_dec(head_tnew_q);
                end
            end else if (push) begin
                head_valid_d   = 1'b1;
                head_pc_d      = in_pc;
                head_tnew_d    = sat_dec(in_tnew);
                head_payload_d = in_payload;
            end
`else
            if (push) begin
                head_valid_d   = 1'b1;
                head_pc_d      = in_pc;
                head_tnew_d    = sat_dec(in_tnew);
                head_payload_d = in_payload;
            end else if (pop) begin
                head_valid_d = 1'b0;
            end else if (head_valid_q) begin
                head_tnew_d = sat_dec(head_tnew_q);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_valid_q   <= 1'b0;
            head_pc_q      <= '0;
            head_tnew_q    <= '0;
            head_payload_q <= '0;
        end else begin
            head_valid_q   <= head_valid_d;
            head_pc_q      <= head_pc_d;
            head_tnew_q    <= head_tnew_d;
            head_payload_q <= head_payload_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_valid_q   <= 1'b0;
            skid_pc_q      <= '0;
            skid_tnew_q    <= '0;
            skid_payload_q <= '0;
        end else begin
            skid_valid_q   <= skid_valid_d;
            skid_pc_q      <= skid_pc_d;
            skid_tnew_q    <= skid_tnew_d;
            skid_payload_q <= skid_payload_d;
        end
    end
`endif

    assign out_valid   = head_valid_q;
    assign out_pc      = head_pc_q;
    assign out_tnew    = head_tnew_q;
    assign out_payload = head_payload_q;

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 32: width of the opaque payload field (instr, A3, data, control bits packed by the user).
REQ-002 Parameter TNEW_W, default 4: width of the Tnew countdown field.
REQ-003 Parameter EXC_PC, default 32'h0000_4180: PC loaded into the output slot on req.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_pc / in_tnew / in_payload  input  32 / TNEW_W / PAYLOAD_W  upstream entry fields.
REQ-009 out_valid  output  1  output slot holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts output entry this cycle.
REQ-011 out_pc / out_tnew / out_payload  output  32 / TNEW_W / PAYLOAD_W  output slot fields, driven directly from registers.
REQ-012 flush  input  1  discard all held entries (bubble insertion).
REQ-013 req  input  1  exception/interrupt request; discard all entries, mark macro-PC.
REQ-014 occupancy  output  2  number of valid entries held (0..2).

Function
REQ-015 Transfer in: in_valid & in_ready at rising edge; transfer out: out_valid & out_ready at rising edge.
REQ-016 Captured tnew SHALL be in_tnew-1, saturating at 0 (in_tnew=0 stores 0).
REQ-017 Every held valid entry not transferred out SHALL decrement its tnew by 1 per cycle, saturating at 0.
REQ-018 While out_valid=1 and out_ready=0, out_pc and out_payload SHALL remain unchanged.
REQ-019 Priority per edge: req > flush > normal handshake; in_valid is ignored on a req/flush cycle.
REQ-020 req SHALL clear all entries, set out_valid=0, out_pc=EXC_PC, out_tnew=0, out_payload=0, occupancy=0.
REQ-021 flush (without req) SHALL clear all entries, set out_valid=0, out_pc=0, out_tnew=0, out_payload=0, occupancy=0.
REQ-022 When out_valid=0 and no req/flush, output fields SHALL hold their last values (not required to zero).
REQ-023 Entries SHALL leave in arrival order; no entry duplicated or dropped except by req/flush.
REQ-024 in_ready SHALL be 1 during the cycle following req or flush.

Reset
REQ-025 On reset=0: out_valid=0, out_pc=0, out_tnew=0, out_payload=0, occupancy=0, skid entry invalid and zeroed.
REQ-026 Reset deassertion mid-operation SHALL leave the stage empty; first accept occurs on the first edge with reset=1.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: two entries (head = output slot, skid); in_ready = !skid_valid, registered, no combinational path from out_ready.
REQ-028 With skid: occupancy 1 + push + pop -> new entry to head; occupancy 1 + push, no pop -> new entry to skid; occupancy 2 + pop -> skid moves to head (its tnew decremented per REQ-017), occupancy 1.
REQ-029 Macro undefined: single output slot; in_ready = out_ready | ~out_valid (combinational); occupancy never exceeds 1.

Verification
REQ-030 Stream: in_valid=1, out_ready=1, pc 0x3000,0x3004,0x3008 -> same pcs out one cycle later each, occupancy=1, in_tnew=2 -> out_tnew=1.
REQ-031 Stall: out_ready=0 for 3 cycles holding entry with in_tnew=3 -> out_tnew 2,1,0,0; out_pc constant; (skid) second entry accepted, third refused, in_ready=0.
REQ-032 Skid drain: occupancy 2, out_ready=1, in_valid=0 -> head then skid entry emitted in order, occupancy 2->1->0.
REQ-033 req and flush same edge with occupancy 2 -> out_valid=0, out_pc=0x0000_4180, occupancy=0, in_ready=1 next cycle.
REQ-034 flush alone with in_valid=1 -> entry not captured, out_pc=0, out_valid=0.
REQ-035 reset=0 asserted mid-cycle with occupancy 2 -> outputs zero before next clock edge; resumes streaming after release.
